// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the dcache request arbiter
package dcache_pkg;

  localparam int XLEN          = 64;
  localparam int PLEN          = 56;
  localparam int NUM_REQ_PORTS = 3;

  typedef enum logic [1:0] {
    PTW        = 2'd0,
    LOAD_UNIT  = 2'd1,
    STORE_UNIT = 2'd2
  } request_port_select_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  function automatic int unsigned port_idx_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/dcache_rr_select.sv
// rtl/dcache_rr_select.sv - PTW fixed priority plus load/store round-robin winner select
module dcache_rr_select
  import dcache_pkg::*;
#(
  parameter int NUM_PORTS = NUM_REQ_PORTS,
  localparam int IDX_W    = port_idx_w(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 advance_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic [NUM_PORTS-1:0] onehot_o
);

  localparam logic [IDX_W-1:0] IDX_PTW   = IDX_W'(PTW);
  localparam logic [IDX_W-1:0] IDX_LOAD  = IDX_W'(LOAD_UNIT);
  localparam logic [IDX_W-1:0] IDX_STORE = IDX_W'(STORE_UNIT);

  // 0 favours the load unit, 1 favours the store unit on a tie
  logic rr_q;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = IDX_PTW;
    if (req_i[PTW]) begin
      valid_o = 1'b1;
      idx_o   = IDX_PTW;
    end else if (req_i[LOAD_UNIT] && req_i[STORE_UNIT]) begin
      valid_o = 1'b1;
      idx_o   = rr_q ? IDX_STORE : IDX_LOAD;
    end else if (req_i[LOAD_UNIT]) begin
      valid_o = 1'b1;
      idx_o   = IDX_LOAD;
    end else if (req_i[STORE_UNIT]) begin
      valid_o = 1'b1;
      idx_o   = IDX_STORE;
    end else begin
      // any extra ports beyond the three CPU units sit below them in fixed order
      for (int i = NUM_PORTS - 1; i >= 3; i--) begin
        if (req_i[i]) begin
          valid_o = 1'b1;
          idx_o   = IDX_W'(i);
        end
      end
    end
  end

  assign onehot_o = valid_o ? (NUM_PORTS'(1) << idx_o) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else if (advance_i && valid_o && (idx_o == IDX_LOAD || idx_o == IDX_STORE)) begin
      rr_q <= (idx_o == IDX_LOAD);
    end
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// rtl/dcache_req_arbiter.sv - funnels PTW/load/store requests into one cache controller port
module dcache_req_arbiter
  import dcache_pkg::*;
#(
  parameter int NUM_PORTS = NUM_REQ_PORTS,
  parameter int ADDR_W    = PLEN
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS-1:0][XLEN/8-1:0]    be_i,
  input  logic [NUM_PORTS-1:0][1:0]           size_i,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]      wdata_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [XLEN-1:0]                     rdata_o,
  output logic                                mem_req_o,
  output logic [ADDR_W-1:0]                   mem_addr_o,
  output logic                                mem_we_o,
  output logic [XLEN/8-1:0]                   mem_be_o,
  output logic [1:0]                          mem_size_o,
  output logic [XLEN-1:0]                     mem_wdata_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [XLEN-1:0]                     mem_rdata_i,
  output logic                                busy_o
);

  localparam int IDX_W = port_idx_w(NUM_PORTS);

  arb_state_t             state_q;
  logic [IDX_W-1:0]       owner_q;
  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_PORTS-1:0]   sel_onehot;
  logic                   accept;
  logic                   load_done;

  dcache_rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .advance_i (accept),
    .valid_o   (sel_valid),
    .idx_o     (sel_idx),
    .onehot_o  (sel_onehot)
  );

  // grant and load response are same-cycle pulses, held low while in reset
  assign accept    = rst_ni && (state_q == IDLE) && sel_valid;
  assign load_done = rst_ni && (state_q == WAIT_RSP) && mem_rvalid_i && !mem_we_o;

  assign gnt_o    = accept ? sel_onehot : '0;
  assign rvalid_o = load_done ? (NUM_PORTS'(1) << owner_q) : '0;
  assign rdata_o  = load_done ? mem_rdata_i : '0;
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_size_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_q     <= WAIT_GNT;
            owner_q     <= sel_idx;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= addr_i[sel_idx];
            mem_we_o    <= we_i[sel_idx];
            mem_be_o    <= be_i[sel_idx];
            mem_size_o  <= size_i[sel_idx];
            mem_wdata_o <= wdata_i[sel_idx];
          end
        end
        WAIT_GNT: begin
          // a completion arriving together with the grant belongs to nothing yet
          if (mem_gnt_i) begin
            state_q   <= WAIT_RSP;
            mem_req_o <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb/tb_dcache_req_arbiter.sv - self-checking bench for dcache_req_arbiter
module tb_dcache_req_arbiter;
  import dcache_pkg::*;

  localparam int NP = 3;
  localparam int AW = PLEN;
  localparam int BW = XLEN / 8;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic [NP-1:0]             req_i;
  logic [NP-1:0][AW-1:0]     addr_i;
  logic [NP-1:0]             we_i;
  logic [NP-1:0][BW-1:0]     be_i;
  logic [NP-1:0][1:0]        size_i;
  logic [NP-1:0][XLEN-1:0]   wdata_i;
  logic [NP-1:0]             gnt_o;
  logic [NP-1:0]             rvalid_o;
  logic [XLEN-1:0]           rdata_o;
  logic                      mem_req_o;
  logic [AW-1:0]             mem_addr_o;
  logic                      mem_we_o;
  logic [BW-1:0]             mem_be_o;
  logic [1:0]                mem_size_o;
  logic [XLEN-1:0]           mem_wdata_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [XLEN-1:0]           mem_rdata_i;
  logic                      busy_o;

  always #5 clk_i = ~clk_i;

  dcache_req_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .size_i       (size_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_size_o   (mem_size_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [NP-1:0] mask;
    int            port;
    logic          we;
    logic [BW-1:0] be;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    int            gnt_delay;
    logic          both;
  } vec_t;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [1:0]    size;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [NP-1:0] mask, input int port, input logic we,
                              input logic [BW-1:0] be, input logic [1:0] size,
                              input logic [AW-1:0] addr, input logic [XLEN-1:0] wdata,
                              input logic [XLEN-1:0] rdata, input int dly, input logic both);
    vec_t v;
    v.mask = mask; v.port = port; v.we = we; v.be = be; v.size = size;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.gnt_delay = dly; v.both = both;
    return v;
  endfunction

  // the expected winner gets the vector fields, every other port gets distinct decoys
  task automatic drive_fields(input vec_t v);
    for (int p = 0; p < NP; p++) begin
      if (p == v.port) begin
        addr_i[p] = v.addr; we_i[p] = v.we; be_i[p] = v.be;
        size_i[p] = v.size; wdata_i[p] = v.wdata;
      end else begin
        addr_i[p] = v.addr ^ (AW'(p + 1) << 12); we_i[p] = ~v.we; be_i[p] = ~v.be;
        size_i[p] = ~v.size; wdata_i[p] = ~v.wdata;
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    exp_t got;
    logic [NP-1:0] oh;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_gnt_i = 1'b0;
    check("idle_busy", busy_o, 0);
    req_i = v.mask;
    drive_fields(v);
    e.port = v.port; e.addr = v.addr; e.we = v.we; e.be = v.be;
    e.size = v.size; e.wdata = v.wdata; e.rdata = v.rdata;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    oh = NP'(1) << got.port;
    check("gnt", gnt_o, oh);
    @(negedge clk_i);
    req_i[got.port] = 1'b0;
    check("gnt_clear", gnt_o, 0);
    check("busy", busy_o, 1);
    check("mem_req", mem_req_o, 1);
    check("mem_addr", mem_addr_o, got.addr);
    check("mem_we", mem_we_o, got.we);
    check("mem_be", mem_be_o, got.be);
    check("mem_size", mem_size_o, got.size);
    check("mem_wdata", mem_wdata_o, got.wdata);
    for (int i = 1; i < v.gnt_delay; i++) begin
      @(negedge clk_i);
      check("stall_req", mem_req_o, 1);
      check("stall_addr", mem_addr_o, got.addr);
      check("stall_gnt", gnt_o, 0);
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b1;
    mem_rvalid_i = v.both;
    mem_rdata_i = ~v.rdata;
    #1;
    check("gntcyc_rvalid", rvalid_o, 0);
    check("gntcyc_req", mem_req_o, 1);
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    check("rsp_req_drop", mem_req_o, 0);
    check("rsp_busy", busy_o, 1);
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = v.rdata;
    #1;
    check("rvalid", rvalid_o, got.we ? '0 : oh);
    check("rdata", rdata_o, got.we ? '0 : got.rdata);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    vec_t v;
    req_i = '1; addr_i = '0; we_i = '0; be_i = '0; size_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    repeat (2) @(negedge clk_i);
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_be", mem_be_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    rst_ni = 1'b1;
    req_i = '0;

    tbl[0] = mk(3'b110, 1, 1'b0, 8'hFF, 2'd3, 'h1000,      'h0,        'h1111,     1, 1'b0);
    tbl[1] = mk(3'b110, 2, 1'b0, 8'hF0, 2'd2, 'h2008,      'h0,        'h2222,     1, 1'b0);
    tbl[2] = mk(3'b110, 1, 1'b0, 8'h0F, 2'd1, 'h3000,      'h0,        'h3333,     3, 1'b0);
    tbl[3] = mk(3'b110, 2, 1'b0, 8'h3C, 2'd0, 'h3010,      'h0,        'h4444,     1, 1'b0);
    tbl[4] = mk(3'b010, 1, 1'b0, 8'h0F, 2'd2, 'h8000_0010, 'h0,        'hDEADBEEF, 2, 1'b0);
    tbl[5] = mk(3'b100, 2, 1'b1, 8'h03, 2'd1, 'h4000,      'hCAFEF00D, 'h5A5A,     1, 1'b0);
    tbl[6] = mk(3'b001, 0, 1'b0, 8'hFF, 2'd3, 'h9000,      'h0,        'h5555,     1, 1'b0);
    tbl[7] = mk(3'b011, 0, 1'b0, 8'hFF, 2'd3, 'h9008,      'h0,        'h6666,     2, 1'b1);
    tbl[8] = mk(3'b110, 1, 1'b0, 8'hC0, 2'd3, 'hA000,      'h0,        'h7777,     1, 1'b0);
    tbl[9] = mk(3'b110, 2, 1'b1, 8'h81, 2'd0, 'hB000,      'h12345678, 'h8888,     1, 1'b0);
    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // PTW beats everything, then load/store round-robin, PTW cutting back in
    do_reset();
    run_txn(mk(3'b111, 0, 1'b0, 8'hFF, 2'd3, 'hC000, 'h0, 'hA0, 1, 1'b0));
    run_txn(mk(3'b110, 1, 1'b0, 8'hFF, 2'd3, 'hC100, 'h0, 'hA1, 1, 1'b0));
    run_txn(mk(3'b101, 0, 1'b0, 8'hFF, 2'd3, 'hC200, 'h0, 'hA2, 1, 1'b0));
    run_txn(mk(3'b100, 2, 1'b0, 8'hFF, 2'd3, 'hC300, 'h0, 'hA3, 1, 1'b0));

    // reset while waiting for the response abandons the transaction
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    v = mk(3'b010, 1, 1'b0, 8'hFF, 2'd3, 'hD000, 'h0, 'hB0, 1, 1'b0);
    req_i = v.mask;
    drive_fields(v);
    #1;
    check("abort_gnt", gnt_o, 3'b010);
    @(negedge clk_i);
    req_i = '0;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    check("abort_busy", busy_o, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 'hBAD;
    #1;
    check("abort_rvalid", rvalid_o, 0);
    check("abort_rdata", rdata_o, 0);
    check("abort_busy0", busy_o, 0);
    check("abort_mem_req", mem_req_o, 0);
    check("abort_mem_addr", mem_addr_o, 0);
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    check("abort_stay_idle", busy_o, 0);
    run_txn(mk(3'b110, 1, 1'b0, 8'h11, 2'd2, 'hE000, 'h0, 'hB1, 1, 1'b0));

    // spurious completion and grant while idle
    @(negedge clk_i);
    req_i = '0;
    mem_rvalid_i = 1'b1;
    mem_gnt_i = 1'b1;
    mem_rdata_i = 'hFEED;
    #1;
    check("spur_rvalid", rvalid_o, 0);
    check("spur_rdata", rdata_o, 0);
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_gnt_i = 1'b0;
    check("spur_busy", busy_o, 0);
    check("spur_mem_req", mem_req_o, 0);

    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d checks so far", tests);
    $fatal(1);
  end

endmodule

// File: doc/dcache_req_arbiter.md
DCACHE_REQ_ARBITER -- requirements
Module: dcache_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of CPU request ports: 0=PTW, 1=load unit, 2=store unit.
REQ-002 SHALL have parameter ADDR_W, default riscv::PLEN, physical request address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req_i, input, NUM_PORTS, per-port request valid.
REQ-006 SHALL have ports addr_i/we_i/be_i/size_i/wdata_i, input, NUM_PORTS x ADDR_W/1/XLEN/8/2/XLEN, per-port request fields.
REQ-007 SHALL have port gnt_o, input-side output, NUM_PORTS, one-cycle accept pulse to the requesting port.
REQ-008 SHALL have ports rvalid_o (NUM_PORTS) and rdata_o (XLEN), output, per-port load response valid and shared read data.
REQ-009 SHALL have ports mem_req_o/mem_addr_o/mem_we_o/mem_be_o/mem_size_o/mem_wdata_o, output, 1/ADDR_W/1/XLEN/8/2/XLEN, single request to the cache controller.
REQ-010 SHALL have ports mem_gnt_i (1), mem_rvalid_i (1), mem_rdata_i (XLEN), input, cache controller accept, completion and load data.
REQ-011 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RSP.
REQ-013 In IDLE with any req_i high, SHALL select a winner, pulse gnt_o[winner] that cycle, latch winner's fields and index, and move to WAIT_GNT.
REQ-014 Priority: PTW (port 0) SHALL always win; ports 1 and 2 SHALL alternate round-robin via a 1-bit pointer, updated only when port 1 or 2 wins.
REQ-015 Round-robin pointer SHALL favour the port that did not win last; after reset it favours port 1 (load).
REQ-016 In WAIT_GNT, mem_req_o SHALL be high with latched fields stable; on mem_gnt_i, SHALL drop mem_req_o next cycle and move to WAIT_RSP.
REQ-017 In WAIT_RSP, on mem_rvalid_i, SHALL pulse rvalid_o[owner] combinationally with rdata_o=mem_rdata_i only if latched we=0, and return to IDLE.
REQ-018 Store completion (we=1) SHALL return to IDLE on mem_rvalid_i without any rvalid_o pulse.
REQ-019 Minimum request-to-request spacing SHALL be: accept cycle, >=1 WAIT_GNT cycle, >=1 WAIT_RSP cycle; new accept earliest in the cycle after mem_rvalid_i.
REQ-020 gnt_o SHALL be one-hot or zero; rvalid_o SHALL be one-hot or zero; gnt_o SHALL be zero outside IDLE.
REQ-021 req_i changes while not IDLE SHALL be ignored; ports hold req_i until gnt_o.
REQ-022 mem_rvalid_i in IDLE or WAIT_GNT, and mem_gnt_i outside WAIT_GNT, SHALL be ignored (no state change, no rvalid_o).
REQ-023 mem_gnt_i and mem_rvalid_i high in the same WAIT_GNT cycle SHALL be treated as gnt only.
REQ-024 mem_size_o/mem_addr_o SHALL pass latched values unmodified; alignment is the cache's job.

Reset
REQ-025 While rst_ni=0 at a clock edge: state=IDLE, pointer=favour port 1, latched fields=0, mem_req_o=0, gnt_o=0, rvalid_o=0, rdata_o=0, busy_o=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction; a later mem_rvalid_i SHALL be ignored per REQ-022.

Structure
REQ-027 arb_state_t enum, NUM_REQ_PORTS constant, and port indices (reuse request_port_select_t) SHALL live in dcache_pkg.
REQ-028 One sub-module dcache_rr_select (fixed-priority port 0 plus 2-way round-robin, combinational select plus pointer register) SHALL be instantiated; all else inline.

Verification
REQ-029 Load on port 1 addr 0x8000_0010, mem_gnt_i after 2 cycles, mem_rvalid_i data 0xDEADBEEF -> gnt_o=3'b010 once, rvalid_o=3'b010 with rdata_o=0xDEADBEEF, back to IDLE.
REQ-030 Ports 1 and 2 held high together for 4 transactions -> grant order 1,2,1,2.
REQ-031 All three ports high after reset -> port 0 granted first, then 1, then 2; PTW re-asserted before 3rd accept wins again.
REQ-032 Store port 2, we=1, be=4'b0011 -> mem_we_o=1, mem_be_o=4'b0011, no rvalid_o pulse on completion.
REQ-033 rst_ni low for 1 cycle in WAIT_RSP, then mem_rvalid_i -> all outputs 0, no rvalid_o, next req_i accepted normally.
REQ-034 Spurious mem_rvalid_i in IDLE and mem_gnt_i with mem_rvalid_i same cycle in WAIT_GNT -> no state change / gnt-only handling respectively.
